// File: rtl/sm_arb.sv
// Round-robin arbiter sharing one sum-every-3 datapath among N requesters, with owner-tag return routing.
// Optional define SM_ARB_TIMEOUT_EN pads a stalled group with zero beats after TIMEOUT idle cycles.
module sm_arb #(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_dval,
    input  logic [4*N-1:0]       i,
    output logic [N-1:0]         i_rdy,
    output logic                 dp_dval,
    output logic [3:0]           dp_i,
    input  logic                 dp_o_dval,
    input  logic [5:0]           dp_o,
    output logic                 o_dval,
    output logic [$clog2(N)-1:0] o_id,
    output logic [5:0]           o,
    output logic                 err
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
`ifdef SM_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
`endif

    if (N < 2 || N > 8 || DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("sm_arb: N must be 2..8, DEPTH at least 2, TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1
`ifdef SM_ARB_TIMEOUT_EN
        , PAD = 2'd2
`endif
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [1:0]      r_count;
    logic [IW-1:0]   r_tags [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_occ;
    logic            r_dp_dval;
    logic [3:0]      r_dp_i;
    logic            r_o_dval;
    logic [IW-1:0]   r_o_id;
    logic [5:0]      r_o;
    logic            r_err;
`ifdef SM_ARB_TIMEOUT_EN
    logic [SW-1:0]   r_stall;
    logic [SW-1:0]   w_stall_nx;
`endif

    state_t          w_state_nx;
    logic [IW-1:0]   w_owner_nx;
    logic [IW-1:0]   w_last_nx;
    logic [1:0]      w_count_nx;
    logic            w_push;
    logic            w_pop;
    logic            w_xfer;
    logic            w_beat;
    logic [3:0]      w_beat_data;
    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_idx;
    logic            w_has_room;
    logic [3:0]      w_sample;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_sample   = i[{r_owner, 2'b00} +: 4];
    assign w_has_room = r_occ < CW'(DEPTH);
    assign w_pop      = dp_o_dval && (r_occ != '0);

    // Rotating priority search starting just after the last completed owner.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int j = 1; j <= N; j++) begin
            w_idx = IW'((int'(r_last) + j) % N);
            if (!w_found && i_dval[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_last_nx   = r_last;
        w_count_nx  = r_count;
        w_push      = 1'b0;
        w_xfer      = 1'b0;
        w_beat      = 1'b0;
        w_beat_data = 4'd0;
        i_rdy       = '0;
`ifdef SM_ARB_TIMEOUT_EN
        w_stall_nx  = r_stall;
`endif
        case (r_state)
            IDLE: begin
`ifdef SM_ARB_TIMEOUT_EN
                w_stall_nx = '0;
`endif
                if (w_found && w_has_room) begin
                    w_owner_nx = w_sel;
                    w_push     = 1'b1;
                    w_count_nx = 2'd0;
                    w_state_nx = BURST;
                end
            end
            BURST: begin
                i_rdy[r_owner] = 1'b1;
                w_xfer         = i_dval[r_owner];
                if (w_xfer) begin
                    w_beat      = 1'b1;
                    w_beat_data = w_sample;
`ifdef SM_ARB_TIMEOUT_EN
                    w_stall_nx  = '0;
`endif
                    if (r_count == 2'd2) begin
                        w_state_nx = IDLE;
                        w_last_nx  = r_owner;
                        w_count_nx = 2'd0;
                    end else begin
                        w_count_nx = r_count + 2'd1;
                    end
                end
`ifdef SM_ARB_TIMEOUT_EN
                else if (r_stall == SW'(TIMEOUT - 1)) begin
                    w_state_nx = PAD;
                    w_stall_nx = '0;
                end else begin
                    w_stall_nx = r_stall + 1'b1;
                end
`endif
            end
`ifdef SM_ARB_TIMEOUT_EN
            // Zero beats complete the group so the datapath never holds a mixed-owner sum.
            PAD: begin
                w_beat = 1'b1;
                if (r_count == 2'd2) begin
                    w_state_nx = IDLE;
                    w_last_nx  = r_owner;
                    w_count_nx = 2'd0;
                end else begin
                    w_count_nx = r_count + 2'd1;
                end
            end
`endif
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_last    <= IW'(N - 1);
            r_count   <= 2'd0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_dp_dval <= 1'b0;
            r_dp_i    <= 4'd0;
            r_o_dval  <= 1'b0;
            r_o_id    <= '0;
            r_o       <= 6'd0;
            r_err     <= 1'b0;
`ifdef SM_ARB_TIMEOUT_EN
            r_stall   <= '0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_owner   <= w_owner_nx;
            r_last    <= w_last_nx;
            r_count   <= w_count_nx;
`ifdef SM_ARB_TIMEOUT_EN
            r_stall   <= w_stall_nx;
`endif
            if (w_push) begin
                r_tags[r_wptr] <= w_owner_nx;
                r_wptr         <= nextPtr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= nextPtr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            r_dp_dval <= w_beat;
            if (w_beat) begin
                r_dp_i <= w_beat_data;
            end
            r_o_dval <= w_pop;
            if (w_pop) begin
                r_o    <= dp_o;
                r_o_id <= r_tags[r_rptr];
            end
            if (dp_o_dval && (r_occ == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dp_dval = r_dp_dval;
    assign dp_i    = r_dp_i;
    assign o_dval  = r_o_dval;
    assign o_id    = r_o_id;
    assign o       = r_o;
    assign err     = r_err;

endmodule

// File: tb/tb_sm_arb.sv
// Self-checking bench for sm_arb: group-level round-robin model plus a small sum-every-3 datapath stand-in.
// The padding scenario runs only when SM_ARB_TIMEOUT_EN is defined.
module tb_sm_arb;

    localparam int N       = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         i_dval;
    logic [4*N-1:0]       i;
    logic [N-1:0]         i_rdy;
    logic                 dp_dval;
    logic [3:0]           dp_i;
    logic                 dp_o_dval;
    logic [5:0]           dp_o;
    logic                 o_dval;
    logic [$clog2(N)-1:0] o_id;
    logic [5:0]           o;
    logic                 err;

    sm_arb #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .i_dval(i_dval), .i(i), .i_rdy(i_rdy),
        .dp_dval(dp_dval), .dp_i(dp_i), .dp_o_dval(dp_o_dval), .dp_o(dp_o),
        .o_dval(o_dval), .o_id(o_id), .o(o), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Producer scripts: per requester a list of samples, each with idle cycles to wait before it.
    logic [3:0] prodData [N][16];
    int         prodGap  [N][16];
    int         prodLen  [N];
    int         prodHead [N];
    int         prodWait [N];

    int         expDp[$];
    int         expOid[$];
    int         expOsum[$];
    logic [5:0] retQ[$];
    logic [5:0] acc;
    int         accCnt;
    bit         dpHold;
    bit         injectRet;
    int         mLast;
    int         dpBeats;
    int         rdy1Cycles;
    int         otherRdy;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic refreshDrive();
        for (int k = 0; k < N; k++) begin
            if (prodHead[k] < prodLen[k] && prodWait[k] == 0) begin
                i_dval[k]    = 1'b1;
                i[4*k +: 4]  = prodData[k][prodHead[k]];
            end else begin
                i_dval[k] = 1'b0;
            end
        end
    endtask

    task automatic loadBeat(input int k, input int d, input int gap);
        prodData[k][prodLen[k]] = 4'(d);
        prodGap[k][prodLen[k]]  = gap;
        if (prodLen[k] == prodHead[k]) prodWait[k] = gap;
        prodLen[k]++;
    endtask

    // Group-level model: each grant goes to the next requester after the last owner that has work queued.
    function automatic void buildExpected();
        int h[N];
        int k;
        int found;
        int sum;
        for (int q = 0; q < N; q++) h[q] = prodHead[q];
        for (int g = 0; g < 32; g++) begin
            found = -1;
            for (int j = 1; j <= N; j++) begin
                k = (mLast + j) % N;
                if (found < 0 && h[k] < prodLen[k]) found = k;
            end
            if (found >= 0) begin
                sum = 0;
                for (int b = 0; b < 3; b++) begin
                    expDp.push_back(int'(prodData[found][h[found]]));
                    sum += int'(prodData[found][h[found]]);
                    h[found]++;
                end
                expOid.push_back(found);
                expOsum.push_back(sum);
                mLast = found;
            end
        end
    endfunction

    task automatic applyStimulus();
        logic [N-1:0] xm;
        @(negedge clk);
        xm = i_dval & i_rdy;
        if (dp_dval && !rst) begin
            acc = acc + {2'b00, dp_i};
            accCnt++;
            if (accCnt == 3) begin
                retQ.push_back(acc);
                acc    = 6'd0;
                accCnt = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (xm[k] && prodHead[k] < prodLen[k]) begin
                prodHead[k]++;
                prodWait[k] = (prodHead[k] < prodLen[k]) ? prodGap[k][prodHead[k]] : 0;
            end else if (prodWait[k] > 0) begin
                prodWait[k]--;
            end
        end
        refreshDrive();
        if (injectRet) begin
            dp_o_dval = 1'b1;
            dp_o      = 6'd33;
            injectRet = 1'b0;
        end else if (!dpHold && retQ.size() > 0) begin
            dp_o_dval = 1'b1;
            dp_o      = retQ.pop_front();
        end else begin
            dp_o_dval = 1'b0;
        end
    endtask

    task automatic resetDut(input string name);
        rst       = 1'b1;
        dp_o_dval = 1'b0;
        dpHold    = 1'b0;
        injectRet = 1'b0;
        for (int k = 0; k < N; k++) begin
            prodLen[k]  = 0;
            prodHead[k] = 0;
            prodWait[k] = 0;
        end
        refreshDrive();
        retQ.delete();
        expDp.delete();
        expOid.delete();
        expOsum.delete();
        acc    = 6'd0;
        accCnt = 0;
        mLast  = N - 1;
        applyStimulus();
        applyStimulus();
        checkOutput({name, " i_rdy"},   int'(i_rdy),   0);
        checkOutput({name, " dp_dval"}, int'(dp_dval), 0);
        checkOutput({name, " dp_i"},    int'(dp_i),    0);
        checkOutput({name, " o_dval"},  int'(o_dval),  0);
        checkOutput({name, " o_id"},    int'(o_id),    0);
        checkOutput({name, " o"},       int'(o),       0);
        checkOutput({name, " err"},     int'(err),     0);
        rst = 1'b0;
    endtask

    task automatic runUntilDone(input string name, input int maxCycles);
        int n = 0;
        while ((expDp.size() != 0 || expOid.size() != 0) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput({"drain ", name}, expDp.size() + expOid.size(), 0);
        repeat (4) applyStimulus();
    endtask

    // Every beat and every routed sum is checked against the model's expected streams.
    always @(negedge clk) begin
        if (!rst) begin
            if (dp_dval) begin
                dpBeats++;
                if (expDp.size() == 0) checkOutput("dp beat unexpected", 1, 0);
                else checkOutput("dp_i", int'(dp_i), expDp.pop_front());
            end
            if (o_dval) begin
                if (expOid.size() == 0) begin
                    checkOutput("o_dval unexpected", 1, 0);
                end else begin
                    checkOutput("o_id", int'(o_id), expOid.pop_front());
                    checkOutput("o", int'(o), expOsum.pop_front());
                end
            end
            if (i_rdy[1]) rdy1Cycles++;
            if ((i_rdy & 4'b1101) != 4'b0000) otherRdy++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not finish, limit %0d ns", 500000);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        i_dval    = '0;
        i         = '0;
        dp_o_dval = 1'b0;
        dp_o      = 6'd0;
        dpBeats   = 0;
        rdy1Cycles = 0;
        otherRdy  = 0;
        resetDut("power-on");

        $display("[TB] single requester");
        loadBeat(1, 3, 0); loadBeat(1, 5, 0); loadBeat(1, 7, 0);
        buildExpected();
        checkOutput("model single id", expOid[0], 1);
        checkOutput("model single sum", expOsum[0], 15);
        rdy1Cycles = 0;
        otherRdy   = 0;
        refreshDrive();
        runUntilDone("single", 40);
        checkOutput("single rdy1 cycles", rdy1Cycles, 3);
        checkOutput("single other rdy", otherRdy, 0);

        $display("[TB] round robin");
        resetDut("rr reset");
        for (int b = 0; b < 6; b++) begin
            loadBeat(0, 1, 0);
            loadBeat(2, 4, 0);
        end
        buildExpected();
        checkOutput("model rr id0", expOid[0], 0);
        checkOutput("model rr id1", expOid[1], 2);
        checkOutput("model rr id2", expOid[2], 0);
        checkOutput("model rr id3", expOid[3], 2);
        checkOutput("model rr sum1", expOsum[1], 12);
        refreshDrive();
        runUntilDone("round robin", 80);

        $display("[TB] grant lock");
        resetDut("lock reset");
        loadBeat(0, 2, 0); loadBeat(0, 2, 5); loadBeat(0, 2, 0);
        loadBeat(3, 8, 0); loadBeat(3, 8, 0); loadBeat(3, 8, 0);
        buildExpected();
        checkOutput("model lock id", expOid[0], 0);
        checkOutput("model lock sum", expOsum[0], 6);
        refreshDrive();
        runUntilDone("grant lock", 80);

        $display("[TB] tag fifo full");
        resetDut("full reset");
        for (int b = 1; b <= 6; b++) loadBeat(0, b, 0);
        for (int b = 0; b < 3; b++) begin
            loadBeat(1, 3, 0);
            loadBeat(2, 5, 0);
            loadBeat(3, 7, 0);
        end
        buildExpected();
        checkOutput("model full last sum", expOsum[4], 15);
        dpHold  = 1'b1;
        dpBeats = 0;
        refreshDrive();
        repeat (30) applyStimulus();
        checkOutput("full beats before release", dpBeats, 12);
        checkOutput("full i_rdy withheld", int'(i_rdy), 0);
        checkOutput("full o_dval held", int'(o_dval), 0);
        dpHold = 1'b0;
        runUntilDone("fifo full", 80);

        $display("[TB] error on empty fifo");
        resetDut("err reset");
        injectRet = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("err set", int'(err), 1);
        repeat (5) applyStimulus();
        checkOutput("err sticky", int'(err), 1);
        checkOutput("err no o_dval", int'(o_dval), 0);

        $display("[TB] reset mid-burst");
        resetDut("pre-burst reset");
        loadBeat(1, 5, 0); loadBeat(1, 6, 0);
        expDp.push_back(5);
        expDp.push_back(6);
        dpBeats = 0;
        refreshDrive();
        for (int n = 0; n < 20 && dpBeats < 2; n++) applyStimulus();
        checkOutput("partial beats", dpBeats, 2);
        resetDut("mid-burst reset");
        loadBeat(1, 1, 0); loadBeat(1, 2, 0); loadBeat(1, 3, 0);
        buildExpected();
        checkOutput("model fresh sum", expOsum[0], 6);
        refreshDrive();
        runUntilDone("after reset", 40);

`ifdef SM_ARB_TIMEOUT_EN
        $display("[TB] timeout padding");
        resetDut("timeout reset");
        loadBeat(2, 9, 0);
        expDp.push_back(9);
        expDp.push_back(0);
        expDp.push_back(0);
        expOid.push_back(2);
        expOsum.push_back(9);
        mLast = 2;
        refreshDrive();
        runUntilDone("timeout", 60);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
